// File: rtl/int_ctrl.sv
// Fixed-priority nested interrupt controller.
// Lines latch into a pending register, either on a rising edge or while held
// high. The highest enabled pending line is offered to the control unit only
// when it outranks the highest line already in service. An accepted call moves
// that line from pending to in-service, and return-from-interrupt retires the
// highest in-service line. Line N_IRQ-1 has the highest priority.
module int_ctrl #(
  parameter int N_IRQ   = 8,  // 2..16 interrupt lines
  parameter int VEC_W   = 3,  // 2**VEC_W >= N_IRQ
  parameter int DEPTH_W = 4,  // 2**DEPTH_W > N_IRQ
  parameter int EDGE    = 1   // 1 = rising-edge capture, 0 = level capture
) (
  input  logic               clk,
  input  logic               reset,       // asynchronous, active low
  input  logic [N_IRQ-1:0]   irq_in,
  input  logic               mask_we,
  input  logic [N_IRQ-1:0]   mask_din,
  input  logic               irq_ack,
  input  logic               reti,
  output logic               irq_req,
  output logic [VEC_W-1:0]   irq_vec,
  output logic [N_IRQ-1:0]   irq_onehot,
  output logic [N_IRQ-1:0]   isr_onehot,
  output logic [DEPTH_W-1:0] nest_depth,
  output logic [N_IRQ-1:0]   pending,
  output logic [N_IRQ-1:0]   in_service
);

  // Registered state and its next-state values
  logic [N_IRQ-1:0] irq_q, irq_d;
  logic             armed_q, armed_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] in_service_q, in_service_d;

  // Decoded view of the registered state
  logic [N_IRQ-1:0] set_vec;
  logic [N_IRQ-1:0] enabled;
  logic             p_valid, s_valid;
  logic [VEC_W-1:0] p_idx, s_idx;
  logic [N_IRQ-1:0] p_oh, s_oh;
  logic             ack_fire, reti_fire;

  // Capture detection. In edge mode nothing is detected on the first edge
  // after reset, so irq_q can first take a copy of the lines: a line that was
  // already high when reset released is then not mistaken for a new edge.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path through the block leaves it holding a value (latch).
    set_vec = '0;
    if (EDGE != 0) begin
      if (armed_q) set_vec = irq_in & ~irq_q;
    end else begin
      set_vec = irq_in;
    end
  end

  // Priority encoders: P over enabled pending lines, S over in-service lines.
  // Scanning upward lets the highest set index win.
  always_comb begin
    enabled = pending_q & mask_q;
    p_valid = 1'b0;
    p_idx   = '0;
    s_valid = 1'b0;
    s_idx   = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (enabled[i]) begin
        p_valid = 1'b1;
        p_idx   = VEC_W'(i);
      end
      if (in_service_q[i]) begin
        s_valid = 1'b1;
        s_idx   = VEC_W'(i);
      end
    end
    p_oh = N_IRQ'(1) << p_idx;
    s_oh = N_IRQ'(1) << s_idx;
  end

  // Request and vector outputs, derived only from registered state
  always_comb begin
    irq_req    = p_valid && (!s_valid || (p_idx > s_idx));
    irq_vec    = irq_req ? p_idx : '0;
    irq_onehot = irq_req ? p_oh  : '0;
    isr_onehot = s_valid ? s_oh  : '0;
  end

  // Nesting depth is the population count of the in-service register
  always_comb begin
    nest_depth = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      nest_depth = nest_depth + DEPTH_W'(in_service_q[i]);
    end
  end

  // Next state. Ack and reti both act on the pre-edge P and S. Because an
  // accepted ack needs P > S, the two touch different in-service bits and the
  // depth stays the same when both happen. A new capture is OR-ed in after the
  // ack clear, so a set on the acknowledged line wins.
  always_comb begin
    ack_fire     = irq_ack & irq_req;
    reti_fire    = reti & s_valid;
    irq_d        = irq_in;
    armed_d      = 1'b1;
    mask_d       = mask_we ? mask_din : mask_q;
    pending_d    = pending_q;
    in_service_d = in_service_q;
    if (ack_fire) begin
      pending_d    = pending_d & ~p_oh;
      in_service_d = in_service_d | p_oh;
    end
    if (reti_fire) begin
      in_service_d = in_service_d & ~s_oh;
    end
    pending_d = pending_d | set_vec;
  end

  // State register. Reset clears all service state at once, and every line
  // becomes enabled again.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q        <= '0;
      armed_q      <= 1'b0;
      mask_q       <= '1;
      pending_q    <= '0;
      in_service_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples its pre-edge inputs regardless of statement order.
      irq_q        <= irq_d;
      armed_q      <= armed_d;
      mask_q       <= mask_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
    end
  end

  assign pending    = pending_q;
  assign in_service = in_service_q;

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter N_IRQ, default 8: number of interrupt lines; SHALL be 2..16.
REQ-002 Parameter VEC_W, default 3: width of irq_vec; SHALL satisfy 2^VEC_W >= N_IRQ.
REQ-003 Parameter DEPTH_W, default 4: width of nest_depth; SHALL satisfy 2^DEPTH_W > N_IRQ.
REQ-004 Parameter EDGE, default 1: 1 = rising-edge capture, 0 = level capture.
REQ-005 clk  in  1  single system clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-007 irq_in  in  N_IRQ  external interrupt request lines, synchronous to clk.
REQ-008 mask_we  in  1  write strobe for the enable mask.
REQ-009 mask_din  in  N_IRQ  new enable mask; bit = 1 enables that line.
REQ-010 irq_ack  in  1  control unit accepts the presented interrupt (call taken).
REQ-011 reti  in  1  control unit executes return-from-interrupt.
REQ-012 irq_req  out  1  an enabled interrupt outranks the current service level.
REQ-013 irq_vec  out  VEC_W  index of the highest-priority enabled pending line.
REQ-014 irq_onehot  out  N_IRQ  one-hot form of irq_vec; all zero when irq_req = 0.
REQ-015 isr_onehot  out  N_IRQ  one-hot of the highest in-service line, for return selection.
REQ-016 nest_depth  out  DEPTH_W  number of set in-service bits.
REQ-017 pending  out  N_IRQ  pending register.
REQ-018 in_service  out  N_IRQ  in-service register.

Function
REQ-019 Priority SHALL be fixed: a higher index means higher priority; line N_IRQ-1 is highest.
REQ-020 With EDGE = 1, the block SHALL register irq_in each cycle as irq_q; pending[i] SHALL set when irq_in[i] & ~irq_q[i].
REQ-021 With EDGE = 0, pending[i] SHALL set in every cycle in which irq_in[i] = 1.
REQ-022 Masked lines SHALL still latch pending; the mask SHALL gate only request generation.
REQ-023 Let P = highest index of pending & mask, and S = highest index of in_service. irq_req SHALL be asserted combinationally from registered state when P exists and (in_service = 0 or P > S).
REQ-024 irq_vec SHALL equal P when irq_req = 1 and 0 otherwise; irq_onehot SHALL equal 1 << P when irq_req = 1 and 0 otherwise.
REQ-025 isr_onehot SHALL equal 1 << S, or 0 when in_service = 0.
REQ-026 irq_ack with irq_req = 1 SHALL clear pending[P], set in_service[P] and increment nest_depth on the next edge; irq_ack with irq_req = 0 SHALL be ignored.
REQ-027 reti with in_service != 0 SHALL clear in_service[S] and decrement nest_depth; reti with in_service = 0 SHALL be ignored, with no underflow.
REQ-028 Simultaneous irq_ack and reti SHALL use the pre-edge P and S; both updates SHALL apply and nest_depth SHALL remain unchanged.
REQ-029 A pending set and an ack-clear on the same line in the same cycle SHALL resolve set-wins, so pending stays 1.
REQ-030 mask_we SHALL load mask from mask_din on the next edge; the new mask SHALL affect irq_req from the following cycle.
REQ-031 irq_req SHALL deassert in the cycle after an accepted ack unless a strictly higher enabled line is pending.
REQ-032 A lower- or equal-priority pending line SHALL be held (no nesting) until reti lowers S below it.

Reset
REQ-033 While reset = 0: pending = 0, in_service = 0, irq_q = 0, mask = all ones, nest_depth = 0, irq_req = 0, irq_vec = 0, irq_onehot = 0, isr_onehot = 0.
REQ-034 Reset asserted mid-service SHALL discard all nesting state immediately, without waiting for a clock edge.
REQ-035 In EDGE = 1 mode, a line already high when reset releases SHALL NOT set pending until it goes low and then high again.

Verification (N_IRQ = 8, EDGE = 1)
REQ-036 Pulse irq_in = 8'h04 -> next cycle irq_req = 1, irq_vec = 2, irq_onehot = 8'h04; ack -> pending = 0, in_service = 8'h04, nest_depth = 1, irq_req = 0.
REQ-037 Line 2 in service, pulse lines 1 and 6 -> irq_vec = 6; ack -> in_service = 8'h44, depth = 2; reti -> in_service = 8'h04; reti -> in_service = 0, then irq_vec = 1 and irq_req = 1.
REQ-038 mask_din = 8'hFE with mask_we, pulse line 0 -> pending = 8'h01, irq_req = 0; mask_din = 8'hFF -> irq_req = 1, irq_vec = 0.
REQ-039 reti with in_service = 0 -> no state change, nest_depth stays 0; irq_ack with irq_req = 0 -> no change.
REQ-040 Line 5 in service, line 7 pending, assert ack and reti together -> in_service = 8'h80, nest_depth stays 1.
REQ-041 Drop reset to 0 asynchronously with depth = 3 -> all outputs 0 at once and mask = 8'hFF; holding irq_in = 8'h01 high across reset release sets no pending.
